reglk_ctrl: RTL and testbench
=============================

# reglk_ctrl

Sequencing and arbitration controller for the register-lock memory (`reglk_mem`): six 32-bit words of lock bits that gate writes to protected registers across the SoC.
- Shares the single lock-memory write path between `NUM_REQ` requesters, such as boot firmware and debug, using a round-robin valid/ready handshake.
- Lock bits are sticky: a normal write can only set bits.
- Clearing bits requires an explicit clear operation while JTAG unlock is asserted.
- The only reset is the global reset. There is no block-local reset, so locks cannot be dropped independently of the rest of the system.

## Interface
Parameters:
- `NUM_WORDS`, 6: number of lock words.
- `DATA_W`, 32: bits per lock word.
- `NUM_REQ`, 2: number of requesters (≥2).
- `ADDR_W`, 3: word address width; fixed at 3 for `NUM_WORDS`=6.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  `NUM_REQ`  request valid, one bit per requester.
- `req_ready_o`  out  `NUM_REQ`  request accepted, one bit per requester.
- `req_clr_i`  in  [`NUM_REQ`] × 1  0 = set operation, 1 = clear operation.
- `req_addr_i`  in  [`NUM_REQ`] × `ADDR_W`  target word.
- `req_data_i`  in  [`NUM_REQ`] × `DATA_W`  bit mask.
- `jtag_unlock_i`  in  1  debug-authenticated unlock.
- `ack_valid_o`  out  1  one-cycle completion pulse.
- `ack_id_o`  out  $clog2(`NUM_REQ`)  requester index of the completed operation.
- `ack_err_o`  out  1  operation rejected; memory unchanged.
- `busy_o`  out  1  FSM not in IDLE.
- `reglk_mem_o`  out  [`NUM_WORDS`] × `DATA_W`  lock words, registered.

## Operation
FSM states are IDLE → EXEC → RESP → IDLE.

**IDLE**
- If any `req_valid_i` bit is set, the round-robin arbiter picks a winner, starting the search at pointer `rr_q`.
- `req_ready_o[winner]`=1 combinationally in that cycle; every other ready bit is 0.
- Op, addr, data and id are latched, the FSM moves to EXEC, and `rr_q` becomes (winner+1) mod `NUM_REQ`.

**EXEC**, error checks in priority order:
- addr ≥ `NUM_WORDS` → err=1, no write.
- clr=1 and `jtag_unlock_i`=0 (sampled in this cycle) → err=1, no write.

**EXEC**, updates when no error:
- Set: `mem[addr] <= mem[addr] | data`.
- Clear: `mem[addr] <= mem[addr] & ~data`.

**RESP**
- `ack_valid_o`=1 with the latched id and err, then return to IDLE.

Handshake rules:
- `req_ready_o` is 0 in every state except IDLE.
- A requester holds valid, addr, data and clr stable until it sees ready.
- Valid must not depend on ready.

Reset:
- `reglk_mem_o` all 0, state IDLE, `rr_q`=0.
- `ack_valid_o`, `ack_err_o`, `ack_id_o` and `busy_o` all 0.
- `req_ready_o` is 0 while `rst_i`=1.

Boundary conditions:
- A set with data=0, or a clear of bits already 0, is legal: err=0, no change.
- The lock memory is never modified outside EXEC.
- `jtag_unlock_i` alone never clears anything.

## Timing
- Accept at cycle T (valid & ready).
- EXEC in T+1. The memory update is visible on `reglk_mem_o` at T+2.
- `ack_valid_o` is high in T+2 only.
- The next accept is possible at T+3 at the earliest, giving a throughput of 1 operation per 3 cycles.
- Arbitration is combinational in IDLE. The pointer update takes effect at T+1.
- Simultaneous requests are serviced in rotating order. A continuously-valid requester waits at most `NUM_REQ`−1 grants.
- `rst_i` asserted in any state:
  - Next cycle: IDLE, memory all 0.
  - The in-flight operation is dropped with no ack and no partial write.
  - Reset has priority over EXEC writes in the same cycle.
- `jtag_unlock_i` toggling outside EXEC has no effect.

## Structure
Shared package `reglk_pkg` holds:
- Constants `NUM_WORDS`, `DATA_W`, `ADDR_W`.
- Type `reglk_word_t`.
- Enum `reglk_state_e` {IDLE, EXEC, RESP}.
- Enum `reglk_op_e` {OP_SET, OP_CLR}.

One sub-module, `reglk_rr_arb`: a parameterized round-robin arbiter with inputs request vector and pointer, and output one-hot grant plus index. The FSM and lock memory live in `reglk_ctrl`.

## Test plan
- **Reset, then idle:** all `reglk_mem_o` words = 0; ack, busy and ready = 0.
- **Sticky set:** req0 set, addr 2, data 0x0000_00F0 → `mem[2]`=0xF0 at T+2 with ack id=0, err=0. Then set 0x0F → `mem[2]`=0xFF.
- **Clear gating, locked:** req1 clear, addr 2, 0xFF, jtag=0 → ack err=1, `mem[2]` stays 0xFF.
- **Clear gating, unlocked:** repeat with jtag=1 → `mem[2]`=0x00, err=0.
- **Arbitration:** both valid continuously from reset → grants 0,1,0,1 at T, T+3, T+6, T+9; ack ids match.
- **Bad address:** addr 6 set 0xFFFF_FFFF → err=1; all six words unchanged.
- **Reset mid-operation:** `rst_i` pulsed during EXEC of a set to addr 0 → no ack; all words 0 the following cycle; the next request is serviced normally.

Source files
------------

// File: rtl/reglk_pkg.sv
// Shared types and constants for the register-lock controller.
// The lock memory holds NUM_WORDS words of sticky lock bits. Bits can only be
// set by normal writes, and cleared by an explicit, JTAG-gated clear.
package reglk_pkg;

  localparam int NUM_WORDS = 6;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 3;

  typedef logic [DATA_W-1:0] reglk_word_t;

  // Sequencer states: accept in IDLE, write in EXEC, acknowledge in RESP.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } reglk_state_e;

  // Operation carried by a request (the requester's clr bit).
  typedef enum logic {
    OP_SET = 1'b0,
    OP_CLR = 1'b1
  } reglk_op_e;

endpackage

// File: rtl/reglk_rr_arb.sv
// Combinational round-robin arbiter.
// The search for a winner starts at requester ptr_i and wraps around. Exactly
// one grant bit is set whenever any request is present; gnt_idx_o is the
// binary index of that grant.
module reglk_rr_arb
  import reglk_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk the requesters in rotating order from the pointer; first hit wins.
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = '0;
    found       = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
        gnt_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reglk_ctrl.sv
// Register-lock controller: arbitrates NUM_REQ requesters onto the single
// write path of the lock memory and sequences each operation through
// IDLE -> EXEC -> RESP. Lock bits are sticky; a clear only takes effect when
// jtag_unlock_i is high in the EXEC cycle. Only the global reset drops locks.
//
// Handshake: a request transfers in the cycle where req_valid_i[k] and
// req_ready_o[k] are both high. Ready is offered combinationally, only in
// IDLE, only to the single arbitration winner, and never during reset. A
// requester keeps valid, clr, addr and data stable until it sees ready, and
// must not derive valid from ready. Completion is a one-cycle ack_valid_o
// pulse carrying the requester id and the error flag, two cycles after the
// transfer.
module reglk_ctrl
  import reglk_pkg::*;
#(
  parameter int NUM_WORDS = reglk_pkg::NUM_WORDS,
  parameter int DATA_W    = reglk_pkg::DATA_W,
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = reglk_pkg::ADDR_W
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0]                  req_clr_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]      req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]      req_data_i,
  input  logic                                jtag_unlock_i,
  output logic                                ack_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]          ack_id_o,
  output logic                                ack_err_o,
  output logic                                busy_o,
  output logic [NUM_WORDS-1:0][DATA_W-1:0]    reglk_mem_o,
  output reglk_state_e                        dbg_state_o
);

  localparam int ID_W = $clog2(NUM_REQ);

  // Sequencer and lock storage
  reglk_state_e                     state_q;
  logic [NUM_WORDS-1:0][DATA_W-1:0] mem_q;
  logic [ID_W-1:0]                  rr_q;

  // Operation latched at accept
  reglk_op_e                        op_q;
  logic [ADDR_W-1:0]                addr_q;
  logic [DATA_W-1:0]                data_q;
  logic [ID_W-1:0]                  id_q;

  // Registered response outputs
  logic                             ack_valid_q;
  logic [ID_W-1:0]                  ack_id_q;
  logic                             ack_err_q;
  logic                             busy_q;

  // Arbiter results
  logic [NUM_REQ-1:0]               gnt;
  logic [ID_W-1:0]                  gnt_idx;
  logic                             gnt_valid;
  logic [ID_W-1:0]                  rr_next;

  // EXEC decision
  logic                             addr_bad;
  logic                             clr_denied;
  logic                             exec_err;

  reglk_rr_arb #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req_i       (req_valid_i),
    .ptr_i       (rr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  // Pointer moves to the requester after the winner, wrapping at NUM_REQ.
  always_comb begin
    rr_next = '0;
    if (gnt_idx != ID_W'(NUM_REQ - 1)) begin
      rr_next = gnt_idx + ID_W'(1);
    end
  end

  // Ready only goes to the winner while idle and out of reset.
  always_comb begin
    req_ready_o = '0;
    if ((state_q == IDLE) && !rst_i) begin
      req_ready_o = gnt;
    end
  end

  // Error checks for the latched operation; bad address takes priority, and
  // the unlock input only matters in the EXEC cycle itself.
  always_comb begin
    addr_bad   = ({1'b0, addr_q} >= (ADDR_W + 1)'(NUM_WORDS));
    clr_denied = (op_q == OP_CLR) && !jtag_unlock_i;
    exec_err   = addr_bad || clr_denied;
  end

  // Sequencer FSM with the lock memory and registered response outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_q       <= '0;
      rr_q        <= '0;
      op_q        <= OP_SET;
      addr_q      <= '0;
      data_q      <= '0;
      id_q        <= '0;
      ack_valid_q <= 1'b0;
      ack_id_q    <= '0;
      ack_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_valid_q <= 1'b0;
          if (gnt_valid) begin
            op_q    <= reglk_op_e'(req_clr_i[gnt_idx]);
            addr_q  <= req_addr_i[gnt_idx];
            data_q  <= req_data_i[gnt_idx];
            id_q    <= gnt_idx;
            rr_q    <= rr_next;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          for (int w = 0; w < NUM_WORDS; w++) begin
            if (!exec_err && (addr_q == ADDR_W'(w))) begin
              if (op_q == OP_CLR) begin
                mem_q[w] <= mem_q[w] & ~data_q;
              end else begin
                mem_q[w] <= mem_q[w] | data_q;
              end
            end
          end
          ack_valid_q <= 1'b1;
          ack_id_q    <= id_q;
          ack_err_q   <= exec_err;
          state_q     <= RESP;
        end
        RESP: begin
          ack_valid_q <= 1'b0;
          ack_id_q    <= '0;
          ack_err_q   <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          ack_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign ack_valid_o = ack_valid_q;
  assign ack_id_o    = ack_id_q;
  assign ack_err_o   = ack_err_q;
  assign busy_o      = busy_q;
  assign reglk_mem_o = mem_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reglk_ctrl.sv
// Bench for reglk_ctrl: directed scenarios plus randomized operations, checked
// against a word-array model of the lock memory and a rotating-priority model
// of the arbiter.
module tb_reglk_ctrl;
  import reglk_pkg::*;

  localparam int NR = 2;
  localparam int NW = 6;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int IW = 1;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]          req_valid = '0;
  logic [NR-1:0]          req_ready;
  logic [NR-1:0]          req_clr = '0;
  logic [NR-1:0][AW-1:0]  req_addr = '0;
  logic [NR-1:0][DW-1:0]  req_data = '0;
  logic                   jtag_unlock = 1'b0;
  logic                   ack_valid;
  logic [IW-1:0]          ack_id;
  logic                   ack_err;
  logic                   busy;
  logic [NW-1:0][DW-1:0]  mem_o;
  reglk_state_e           dbg_state;

  reglk_ctrl #(
    .NUM_WORDS (NW),
    .DATA_W    (DW),
    .NUM_REQ   (NR),
    .ADDR_W    (AW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_clr_i     (req_clr),
    .req_addr_i    (req_addr),
    .req_data_i    (req_data),
    .jtag_unlock_i (jtag_unlock),
    .ack_valid_o   (ack_valid),
    .ack_id_o      (ack_id),
    .ack_err_o     (ack_err),
    .busy_o        (busy),
    .reglk_mem_o   (mem_o),
    .dbg_state_o   (dbg_state)
  );

  // Scoreboard state
  int            checks = 0;
  int            errors = 0;
  logic [31:0]   model_mem [NW];
  int            model_rr = 0;
  logic [IW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    for (int w = 0; w < NW; w++) chk($sformatf("%s_mem%0d", tag, w), mem_o[w], model_mem[w]);
  endtask

  task automatic model_reset();
    for (int w = 0; w < NW; w++) model_mem[w] = '0;
    model_rr = 0;
    exp_q.delete();
  endtask

  function automatic bit model_err(input bit clr, input int addr, input bit jtag);
    return (addr >= NW) || (clr && !jtag);
  endfunction

  task automatic model_apply(input bit clr, input int addr, input logic [31:0] data, input bit jtag);
    if (!model_err(clr, addr, jtag)) begin
      if (clr) model_mem[addr] = model_mem[addr] & ~data;
      else     model_mem[addr] = model_mem[addr] | data;
    end
  endtask

  // Rotating priority: the first valid requester at or after the pointer.
  function automatic int model_winner(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) begin
      if (v[(model_rr + k) % NR]) return (model_rr + k) % NR;
    end
    return -1;
  endfunction

  // Driver: one operation from a single requester, checked cycle by cycle.
  // Called at a negedge; returns at the negedge of the first cycle after RESP.
  task automatic single_op(input int id, input bit clr, input int addr,
                           input logic [31:0] data, input bit jtag, input string tag);
    int c;
    bit err;
    req_valid     = '0;
    req_valid[id] = 1'b1;
    req_clr[id]   = clr;
    req_addr[id]  = addr[AW-1:0];
    req_data[id]  = data;
    jtag_unlock   = 1'($urandom_range(0, 1));
    #1;
    c = 0;
    while (req_ready[id] !== 1'b1 && c < 8) begin
      @(negedge clk); #1; c++;
    end
    chk({tag, "_ready"}, req_ready, 32'(1) << id);
    err = model_err(clr, addr, jtag);
    model_rr = (id + 1) % NR;
    @(posedge clk); #1;
    req_valid   = '0;
    jtag_unlock = jtag;
    @(negedge clk);
    chk({tag, "_exec_state"}, dbg_state, EXEC);
    chk({tag, "_exec_busy"}, busy, 1);
    chk({tag, "_exec_ack"}, ack_valid, 0);
    check_mem({tag, "_exec"});
    model_apply(clr, addr, data, jtag);
    @(posedge clk); #1;
    jtag_unlock = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk({tag, "_ack_v"}, ack_valid, 1);
    chk({tag, "_ack_id"}, ack_id, id);
    chk({tag, "_ack_err"}, ack_err, err);
    chk({tag, "_resp_state"}, dbg_state, RESP);
    check_mem({tag, "_resp"});
    @(negedge clk);
    chk({tag, "_done_ack"}, ack_valid, 0);
    chk({tag, "_done_busy"}, busy, 0);
  endtask

  // Both requesters valid continuously from reset: grants rotate every 3 cycles.
  task automatic arb_test();
    int last_acc;
    int w;
    bit exp_ack;
    rst         = 1'b1;
    req_valid   = '1;
    jtag_unlock = 1'b0;
    for (int k = 0; k < NR; k++) begin
      req_clr[k]  = 1'b0;
      req_addr[k] = AW'($urandom_range(0, NW - 1));
      req_data[k] = $urandom();
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    last_acc = -10;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      exp_ack = (cyc == last_acc + 2);
      chk($sformatf("arb_ack_v_c%0d", cyc), ack_valid, exp_ack);
      if (exp_ack && exp_q.size() > 0) begin
        chk($sformatf("arb_ack_id_c%0d", cyc), ack_id, exp_q.pop_front());
        chk($sformatf("arb_ack_err_c%0d", cyc), ack_err, 0);
        check_mem($sformatf("arb_c%0d", cyc));
      end
      if ((cyc % 3 == 0) && cyc <= 12) begin
        w = model_winner(req_valid);
        chk($sformatf("arb_grant_c%0d", cyc), req_ready, 32'(1) << w);
        exp_q.push_back(IW'(w));
        model_apply(req_clr[w], int'(req_addr[w]), req_data[w], 1'b0);
        model_rr = (w + 1) % NR;
        last_acc = cyc;
        @(posedge clk); #1;
        req_addr[w] = AW'($urandom_range(0, NW - 1));
        req_data[w] = $urandom();
        if (cyc == 12) req_valid = '0;
      end else begin
        chk($sformatf("arb_noready_c%0d", cyc), req_ready, 0);
      end
    end
  endtask

  // Reset asserted during EXEC of a set to word 0: nothing lands, no ack.
  task automatic reset_mid_op();
    int c;
    req_valid    = 2'b01;
    req_clr[0]   = 1'b0;
    req_addr[0]  = '0;
    req_data[0]  = $urandom() | 32'h1;
    jtag_unlock  = 1'b0;
    #1;
    c = 0;
    while (req_ready[0] !== 1'b1 && c < 8) begin
      @(negedge clk); #1; c++;
    end
    chk("rmid_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = '0;
    rst       = 1'b1;
    @(negedge clk);
    chk("rmid_exec_state", dbg_state, EXEC);
    chk("rmid_ready_in_rst", req_ready, 0);
    check_mem("rmid_exec");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rmid_state", dbg_state, IDLE);
    chk("rmid_ack", ack_valid, 0);
    chk("rmid_busy", busy, 0);
    check_mem("rmid_after");
    @(negedge clk);
    chk("rmid_ack_late", ack_valid, 0);
  endtask

  // Stimulus sequence
  initial begin
    model_reset();
    rst       = 1'b1;
    req_valid = '1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_ack", ack_valid, 0);
    chk("rst_err", ack_err, 0);
    chk("rst_id", ack_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, IDLE);
    check_mem("rst");
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("idle_ready", req_ready, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ack", ack_valid, 0);

    single_op(0, 1'b0, 2, 32'h0000_00F0, 1'b0, "set_f0");
    chk("set_f0_word", mem_o[2], 32'h0000_00F0);
    single_op(0, 1'b0, 2, 32'h0000_000F, 1'b0, "set_0f");
    chk("set_0f_word", mem_o[2], 32'h0000_00FF);
    single_op(1, 1'b1, 2, 32'h0000_00FF, 1'b0, "clr_locked");
    chk("clr_locked_word", mem_o[2], 32'h0000_00FF);
    single_op(1, 1'b1, 2, 32'h0000_00FF, 1'b1, "clr_unlocked");
    chk("clr_unlocked_word", mem_o[2], 32'h0000_0000);
    single_op(0, 1'b0, 5, 32'hA5A5_0000, 1'b0, "set_w5");
    single_op(1, 1'b0, 6, 32'hFFFF_FFFF, 1'b1, "bad_addr6");
    single_op(0, 1'b1, 7, 32'hFFFF_FFFF, 1'b1, "bad_addr7");
    single_op(1, 1'b0, 5, 32'h0000_0000, 1'b0, "set_zero");
    single_op(0, 1'b1, 5, 32'h0000_FFFF, 1'b1, "clr_zeros");
    chk("sticky_w5", mem_o[5], 32'hA5A5_0000);

    arb_test();
    reset_mid_op();
    single_op(1, 1'b0, 0, 32'h1234_5678, 1'b0, "post_rst");

    for (int n = 0; n < 40; n++) begin
      single_op($urandom_range(0, NR - 1), 1'($urandom_range(0, 1)),
                $urandom_range(0, 7), $urandom(), 1'($urandom_range(0, 1)),
                $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
